// File: rtl/sr_ff_monitor_pkg.sv
// sr_ff_pkg: shared types for sr_ff_monitor.
//   state_e : monitor FSM states (WAIT, TRACK, FAULT)
//   cmd_e   : S/R command classes (HOLD, SET, RESET, INVALID)
//   decode_cmd(S, R) : maps the sampled S/R pair to its class
package sr_ff_pkg;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_e;

    // Encoded as {S,R} so decode is a straight cast.
    typedef enum logic [1:0] {
        HOLD    = 2'b00,
        RESET   = 2'b01,
        SET     = 2'b10,
        INVALID = 2'b11
    } cmd_e;

    function automatic cmd_e decode_cmd(input logic s, input logic r);
        return cmd_e'({s, r});
    endfunction

endpackage

// File: rtl/sr_ff_monitor_if.sv
// sr_ff_monitor_if: S/R command stream plus the DUT response it produced.
//   S, R  : set / reset commands as driven into the SR flip-flop
//   q, qb : DUT true / complement outputs
// master drives everything (stimulus side + DUT), slave is the monitor.
interface sr_ff_monitor_if;
    logic S;
    logic R;
    logic q;
    logic qb;

    modport master (output S, output R, output q, output qb);
    modport slave  (input  S, input  R, input  q, input  qb);
endinterface

// File: rtl/sr_ff_monitor_sat_counter.sv
// sat_counter: W-bit counter that sticks at all-ones instead of wrapping.
//   clk : clock
//   clr : synchronous clear, wins over inc
//   inc : increment enable
//   cnt : current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clr) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/sr_ff_monitor.sv
// sr_ff_monitor: cycle-level checker for an SR flip-flop DUT.
// Keeps a reference model of q from the sampled S/R commands, compares the
// DUT's q against it every edge once tracking starts, and accumulates
// per-class command counts, mismatch count and the cycle of the first fail.
//   clk, rst            : clock, synchronous active-high reset
//   bus (slave)         : S, R commands and DUT q, qb
//   model_q             : reference value of q
//   err                 : high while in FAULT
//   invalid_seen        : sticky, S=R=1 has been sampled
//   set/reset/hold/invalid_cnt : command counts by class (saturating)
//   mismatch_cnt        : failed compares (saturating)
//   first_fail_cyc      : cyc_cnt at the first failed compare
//   cyc_cnt             : edges since reset (saturating)
// Optional macro SR_FF_MONITOR_QB_CHECK_EN: also require qb == ~q on every
// compare; otherwise qb is ignored.
module sr_ff_monitor
    import sr_ff_pkg::*;
#(
    parameter int CNT_W          = 8,
    parameter bit INVALID_TOGGLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    sr_ff_monitor_if.slave    bus,
    output logic              model_q,
    output logic              err,
    output logic              invalid_seen,
    output logic [CNT_W-1:0]  set_cnt,
    output logic [CNT_W-1:0]  reset_cnt,
    output logic [CNT_W-1:0]  hold_cnt,
    output logic [CNT_W-1:0]  invalid_cnt,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [CNT_W-1:0]  first_fail_cyc,
    output logic [CNT_W-1:0]  cyc_cnt
);

    state_e            state_q, state_d;
    logic              model_q_q, model_q_d;
    logic              invalid_seen_q, invalid_seen_d;
    logic [CNT_W-1:0]  first_fail_cyc_q, first_fail_cyc_d;
    cmd_e              cmd;
    logic              bad;
    logic              fail;

    assign cmd = decode_cmd(bus.S, bus.R);

    // q and model_q were both updated by the previous edge's command, so
    // comparing them now checks the DUT's response to that command.
`ifdef SR_FF_MONITOR_QB_CHECK_EN
    assign bad = (bus.q != model_q_q) || (bus.qb != ~bus.q);
`else
    assign bad = (bus.q != model_q_q);
`endif
    assign fail = (state_q != WAIT) && bad;

    always_comb begin
        state_d          = state_q;
        model_q_d        = model_q_q;
        invalid_seen_d   = invalid_seen_q;
        first_fail_cyc_d = first_fail_cyc_q;

        case (cmd)
            SET:     model_q_d = 1'b1;
            RESET:   model_q_d = 1'b0;
            INVALID: begin
                invalid_seen_d = 1'b1;
                if (INVALID_TOGGLE) model_q_d = ~model_q_q;
            end
            default: model_q_d = model_q_q;
        endcase

        case (state_q)
            WAIT:  state_d = TRACK;
            TRACK: if (fail) begin
                state_d          = FAULT;
                first_fail_cyc_d = cyc_cnt;
            end
            FAULT: state_d = FAULT;
            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= WAIT;
            model_q_q        <= 1'b0;
            invalid_seen_q   <= 1'b0;
            first_fail_cyc_q <= '0;
        end else begin
            state_q          <= state_d;
            model_q_q        <= model_q_d;
            invalid_seen_q   <= invalid_seen_d;
            first_fail_cyc_q <= first_fail_cyc_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_set_cnt (
        .clk(clk), .clr(rst), .inc(cmd == SET),     .cnt(set_cnt));
    sat_counter #(.W(CNT_W)) u_reset_cnt (
        .clk(clk), .clr(rst), .inc(cmd == RESET),   .cnt(reset_cnt));
    sat_counter #(.W(CNT_W)) u_hold_cnt (
        .clk(clk), .clr(rst), .inc(cmd == HOLD),    .cnt(hold_cnt));
    sat_counter #(.W(CNT_W)) u_invalid_cnt (
        .clk(clk), .clr(rst), .inc(cmd == INVALID), .cnt(invalid_cnt));
    sat_counter #(.W(CNT_W)) u_mismatch_cnt (
        .clk(clk), .clr(rst), .inc(fail),           .cnt(mismatch_cnt));
    sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk(clk), .clr(rst), .inc(1'b1),           .cnt(cyc_cnt));

    assign model_q        = model_q_q;
    assign err            = (state_q == FAULT);
    assign invalid_seen   = invalid_seen_q;
    assign first_fail_cyc = first_fail_cyc_q;

endmodule

// File: tb/tb_sr_ff_monitor.sv
// Directed bench for sr_ff_monitor: one 8-bit toggle-on-invalid instance
// and one 2-bit hold-on-invalid instance for saturation checks.
module tb_sr_ff_monitor;
    import sr_ff_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst2;
    sr_ff_monitor_if bus ();
    sr_ff_monitor_if bus2 ();

    logic       model_q, err, invalid_seen;
    logic [7:0] set_cnt, reset_cnt, hold_cnt, invalid_cnt, mismatch_cnt, first_fail_cyc, cyc_cnt;
    logic       model_q2, err2, invalid_seen2;
    logic [1:0] set_cnt2, reset_cnt2, hold_cnt2, invalid_cnt2, mismatch_cnt2, first_fail_cyc2, cyc_cnt2;

    int total = 0;
    int bad   = 0;

    sr_ff_monitor #(.CNT_W(8), .INVALID_TOGGLE(1'b1)) u_dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .model_q(model_q), .err(err), .invalid_seen(invalid_seen),
        .set_cnt(set_cnt), .reset_cnt(reset_cnt), .hold_cnt(hold_cnt),
        .invalid_cnt(invalid_cnt), .mismatch_cnt(mismatch_cnt),
        .first_fail_cyc(first_fail_cyc), .cyc_cnt(cyc_cnt));

    sr_ff_monitor #(.CNT_W(2), .INVALID_TOGGLE(1'b0)) u_sat (
        .clk(clk), .rst(rst2), .bus(bus2.slave),
        .model_q(model_q2), .err(err2), .invalid_seen(invalid_seen2),
        .set_cnt(set_cnt2), .reset_cnt(reset_cnt2), .hold_cnt(hold_cnt2),
        .invalid_cnt(invalid_cnt2), .mismatch_cnt(mismatch_cnt2),
        .first_fail_cyc(first_fail_cyc2), .cyc_cnt(cyc_cnt2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present S/R for the next edge, then drive the DUT response that a
    // correct flip-flop would give (checked at the edge after).
    task automatic cmd(input logic s, input logic r, input logic qn);
        bus.S = s; bus.R = r;
        tick();
        bus.q = qn; bus.qb = ~qn;
    endtask

    task automatic cmd2(input logic s, input logic r, input logic qn);
        bus2.S = s; bus2.R = r;
        tick();
        bus2.q = qn; bus2.qb = ~qn;
    endtask

    task automatic do_reset();
        bus.S = 0; bus.R = 0; bus.q = 0; bus.qb = 1;
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic do_reset2();
        bus2.S = 0; bus2.R = 0; bus2.q = 0; bus2.qb = 1;
        rst2 = 1;
        tick();
        rst2 = 0;
    endtask

    task automatic test_reset();
        rst = 1; bus.S = 1; bus.R = 0; bus.q = 1; bus.qb = 1;
        tick(); tick();
        total++; if (model_q !== 1'b0) begin bad++; $display("FAIL rst_model_q got=%0b exp=0", model_q); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", err); end
        total++; if (set_cnt !== 8'd0) begin bad++; $display("FAIL rst_set_cnt got=%0d exp=0", set_cnt); end
        total++; if (cyc_cnt !== 8'd0) begin bad++; $display("FAIL rst_cyc_cnt got=%0d exp=0", cyc_cnt); end
        total++; if (invalid_seen !== 1'b0) begin bad++; $display("FAIL rst_invalid_seen got=%0b exp=0", invalid_seen); end
        bus.S = 0; bus.q = 0; bus.qb = 1;
        rst = 0;
        for (int i = 0; i < 4; i++) cmd(0, 0, 0);
        total++; if (model_q !== 1'b0) begin bad++; $display("FAIL hold_model_q got=%0b exp=0", model_q); end
        total++; if (hold_cnt !== 8'd4) begin bad++; $display("FAIL hold_cnt got=%0d exp=4", hold_cnt); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL hold_err got=%0b exp=0", err); end
        total++; if (cyc_cnt !== 8'd4) begin bad++; $display("FAIL hold_cyc_cnt got=%0d exp=4", cyc_cnt); end
    endtask

    task automatic test_set_reset();
        logic [3:0] exp_seq;
        logic [3:0] got_seq;
        do_reset();
        exp_seq = 4'b1100;
        cmd(1, 0, 1); got_seq[3] = model_q;
        cmd(0, 0, 1); got_seq[2] = model_q;
        cmd(0, 1, 0); got_seq[1] = model_q;
        cmd(0, 0, 0); got_seq[0] = model_q;
        total++; if (got_seq !== exp_seq) begin bad++; $display("FAIL shrh_model_seq got=%b exp=%b", got_seq, exp_seq); end
        total++; if (set_cnt !== 8'd1) begin bad++; $display("FAIL shrh_set_cnt got=%0d exp=1", set_cnt); end
        total++; if (reset_cnt !== 8'd1) begin bad++; $display("FAIL shrh_reset_cnt got=%0d exp=1", reset_cnt); end
        total++; if (hold_cnt !== 8'd2) begin bad++; $display("FAIL shrh_hold_cnt got=%0d exp=2", hold_cnt); end
        total++; if (mismatch_cnt !== 8'd0) begin bad++; $display("FAIL shrh_mismatch got=%0d exp=0", mismatch_cnt); end
    endtask

    task automatic test_invalid();
        do_reset();
        cmd(1, 1, 1);
        total++; if (model_q !== 1'b1) begin bad++; $display("FAIL inv_model_q1 got=%0b exp=1", model_q); end
        cmd(1, 1, 0);
        total++; if (model_q !== 1'b0) begin bad++; $display("FAIL inv_model_q2 got=%0b exp=0", model_q); end
        total++; if (invalid_cnt !== 8'd2) begin bad++; $display("FAIL inv_cnt got=%0d exp=2", invalid_cnt); end
        cmd(0, 0, 0);
        total++; if (invalid_seen !== 1'b1) begin bad++; $display("FAIL inv_seen got=%0b exp=1", invalid_seen); end
        total++; if (mismatch_cnt !== 8'd0) begin bad++; $display("FAIL inv_mismatch got=%0d exp=0", mismatch_cnt); end
    endtask

    task automatic test_fault();
        do_reset();
        for (int i = 0; i < 4; i++) cmd(0, 0, 0);
        cmd(1, 0, 0);  // set, but DUT response forced wrong
        total++; if (err !== 1'b0) begin bad++; $display("FAIL flt_err_pre got=%0b exp=0", err); end
        total++; if (cyc_cnt !== 8'd5) begin bad++; $display("FAIL flt_cyc got=%0d exp=5", cyc_cnt); end
        cmd(0, 0, 0);  // compare edge at cyc_cnt=5 fails; q stays wrong
        total++; if (err !== 1'b1) begin bad++; $display("FAIL flt_err got=%0b exp=1", err); end
        total++; if (first_fail_cyc !== 8'd5) begin bad++; $display("FAIL flt_first got=%0d exp=5", first_fail_cyc); end
        total++; if (mismatch_cnt !== 8'd1) begin bad++; $display("FAIL flt_mismatch1 got=%0d exp=1", mismatch_cnt); end
        cmd(0, 0, 1);  // second mismatch
        cmd(0, 0, 1);  // correct again
        total++; if (mismatch_cnt !== 8'd2) begin bad++; $display("FAIL flt_mismatch2 got=%0d exp=2", mismatch_cnt); end
        total++; if (first_fail_cyc !== 8'd5) begin bad++; $display("FAIL flt_first_hold got=%0d exp=5", first_fail_cyc); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL flt_err_sticky got=%0b exp=1", err); end
    endtask

    task automatic test_saturation();
        do_reset2();
        for (int i = 0; i < 6; i++) cmd2(1, 0, 1);
        total++; if (set_cnt2 !== 2'd3) begin bad++; $display("FAIL sat_set_cnt got=%0d exp=3", set_cnt2); end
        total++; if (cyc_cnt2 !== 2'd3) begin bad++; $display("FAIL sat_cyc_cnt got=%0d exp=3", cyc_cnt2); end
        total++; if (mismatch_cnt2 !== 2'd0) begin bad++; $display("FAIL sat_mismatch got=%0d exp=0", mismatch_cnt2); end
        cmd2(1, 1, 1);  // invalid holds when INVALID_TOGGLE=0
        total++; if (model_q2 !== 1'b1) begin bad++; $display("FAIL sat_inv_hold got=%0b exp=1", model_q2); end
        total++; if (invalid_seen2 !== 1'b1) begin bad++; $display("FAIL sat_inv_seen got=%0b exp=1", invalid_seen2); end
        cmd2(0, 0, 0);  // wrong response
        cmd2(0, 0, 1);  // fail with cyc_cnt already saturated
        total++; if (err2 !== 1'b1) begin bad++; $display("FAIL sat_err got=%0b exp=1", err2); end
        total++; if (first_fail_cyc2 !== 2'd3) begin bad++; $display("FAIL sat_first got=%0d exp=3", first_fail_cyc2); end
        total++; if (set_cnt2 !== 2'd3) begin bad++; $display("FAIL sat_set_hold got=%0d exp=3", set_cnt2); end
        rst2 = 1; bus2.S = 1; bus2.R = 0;
        tick();
        rst2 = 0; bus2.S = 0;
        total++; if ({set_cnt2, hold_cnt2, invalid_cnt2, mismatch_cnt2, cyc_cnt2, first_fail_cyc2} !== 12'd0) begin
            bad++; $display("FAIL sat_rst_cnts set=%0d hold=%0d inv=%0d mm=%0d cyc=%0d ff=%0d exp=all0",
                            set_cnt2, hold_cnt2, invalid_cnt2, mismatch_cnt2, cyc_cnt2, first_fail_cyc2);
        end
        total++; if (err2 !== 1'b0) begin bad++; $display("FAIL sat_rst_err got=%0b exp=0", err2); end
        total++; if (model_q2 !== 1'b0) begin bad++; $display("FAIL sat_rst_model got=%0b exp=0", model_q2); end
    endtask

    task automatic test_qb();
        logic [7:0] exp_mm1, exp_mm2;
        logic       exp_err1;
`ifdef SR_FF_MONITOR_QB_CHECK_EN
        exp_mm1 = 8'd1; exp_mm2 = 8'd2; exp_err1 = 1'b1;
`else
        exp_mm1 = 8'd0; exp_mm2 = 8'd1; exp_err1 = 1'b0;
`endif
        do_reset();
        cmd(1, 0, 1);
        bus.qb = 1;          // q correct, qb not complementary
        cmd(0, 0, 0);
        bus.qb = 0;          // next: q wrong and qb not complementary
        total++; if (mismatch_cnt !== exp_mm1) begin bad++; $display("FAIL qb_mismatch got=%0d exp=%0d", mismatch_cnt, exp_mm1); end
        total++; if (err !== exp_err1) begin bad++; $display("FAIL qb_err got=%0b exp=%0b", err, exp_err1); end
        tick();
        total++; if (mismatch_cnt !== exp_mm2) begin bad++; $display("FAIL qb_both_once got=%0d exp=%0d", mismatch_cnt, exp_mm2); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL qb_err2 got=%0b exp=1", err); end
    endtask

    initial begin
        rst = 1; rst2 = 1;
        bus.S = 0; bus.R = 0; bus.q = 0; bus.qb = 1;
        bus2.S = 0; bus2.R = 0; bus2.q = 0; bus2.qb = 1;
        test_reset();
        test_set_reset();
        test_invalid();
        test_fault();
        test_saturation();
        test_qb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sr_ff_monitor.md
# sr_ff_monitor

Synthesizable cycle-level checker for the flip-flop conversion blocks in the misc collection. It watches the S/R command stream driven into an SR flip-flop and the q/qb it returns, and keeps a reference model of q. Each DUT response is compared against the model, and operation and mismatch statistics are accumulated. It sits beside any SR-style DUT, in the bench or on-chip, as the receiving end of the S/R command interface.

## Interface
Parameters:
- CNT_W, 8, width of every statistics counter and of the cycle counter
- INVALID_TOGGLE, 1, model behaviour on S=R=1: 1 toggles q, 0 holds q

Ports:
- clk  input  1  clock; all sampling is on the rising edge
- rst  input  1  reset; **synchronous, active-high**
- S  input  1  set command, the same signal driven into the DUT
- R  input  1  reset command, the same signal driven into the DUT
- q  input  1  DUT true output
- qb  input  1  DUT complement output
- model_q  output  1  reference-model value of q
- err  output  1  sticky, high while in FAULT
- invalid_seen  output  1  sticky, high once S=R=1 has been sampled
- set_cnt / reset_cnt / hold_cnt / invalid_cnt  output  CNT_W  counts of sampled S/R commands, by class
- mismatch_cnt  output  CNT_W  number of failed compares
- first_fail_cyc  output  CNT_W  value of cyc_cnt at the first failed compare
- cyc_cnt  output  CNT_W  number of edges since reset

## Operation
- Command classes at each edge:
  - S=1,R=0 is set: model_q becomes 1.
  - S=0,R=1 is reset: model_q becomes 0.
  - S=0,R=0 is hold: model_q keeps its value.
  - S=1,R=1 is invalid: model_q becomes ~model_q if INVALID_TOGGLE=1, otherwise it holds. invalid_seen is set.
- Each edge increments exactly one class counter.
- States:
  - WAIT: entered on reset. Lasts one edge with no compare, then moves to TRACK.
  - TRACK: compare is active. The first failed compare moves the block to FAULT.
  - FAULT: absorbing until rst. Compares and counting continue. err=1.
- Compare, in TRACK and FAULT:
  - At each edge, q is checked against the current model_q. Both were updated by the S/R sampled at the previous edge.
  - A failure increments mismatch_cnt.
  - first_fail_cyc is captured only on the TRACK→FAULT transition.
- Counter rules:
  - All counters saturate at 2^CNT_W−1 and never wrap.
  - cyc_cnt increments every edge in WAIT, TRACK and FAULT.
- Reset values: model_q=0, err=0, invalid_seen=0, all counters 0, first_fail_cyc=0, state WAIT.
- Reset mid-operation: rst=1 at any edge forces the reset values, regardless of S/R/q. Commands sampled during rst are not counted.

## Timing
- Statistics latency: a command sampled at edge k is reflected in the class counters and model_q after edge k.
- DUT latency: the DUT response to the command at edge k must appear on q before edge k+1, and is checked at edge k+1.
- err latency: err rises in the cycle after the failing edge, i.e. registered one cycle after the failed compare.
- No handshake: every edge is one transaction.
- Input conditions: S and R must be stable around the rising edge. q must be settled before the following edge.
- Reset release: the first edge with rst=0 is the WAIT edge. The first compare is at the second edge after rst falls.
- Simultaneous events: a mismatch and a saturated counter on the same edge are both handled. The saturated counter holds, and FAULT is still entered.

## Configuration
- SR_FF_MONITOR_QB_CHECK_EN defined:
  - Every compare also requires qb == ~q.
  - A violation counts as a failed compare: it increments mismatch_cnt and can trigger FAULT.
  - A violation and a q mismatch on the same edge count once.
- SR_FF_MONITOR_QB_CHECK_EN undefined: qb is ignored and has no logic attached.

## Structure
- Shared package sr_ff_pkg holds:
  - the state enum (WAIT, TRACK, FAULT);
  - the command-class enum (HOLD, SET, RESET, INVALID);
  - the decode function mapping S,R to a class.
- One natural sub-module, sat_counter: a CNT_W saturating counter with synchronous clear and an increment enable.
- The block instantiates sat_counter six times: set, reset, hold, invalid, mismatch and cycle.

## Test plan
- Reset plus hold: rst=1 for 2 edges, then S=R=0 for 4 edges, with q following correctly.
  - Required: model_q=0, hold_cnt=4, err=0, cyc_cnt=4.
- Set/hold/reset/hold with a correct DUT.
  - Required: model_q sequence 1,1,0,0; set_cnt=1, reset_cnt=1, hold_cnt=2, mismatch_cnt=0.
- Invalid with INVALID_TOGGLE=1: from model_q=0, apply S=R=1 for 2 edges.
  - Required: model_q goes 1 then 0; invalid_cnt=2, invalid_seen=1.
- Injected fault: after a set, force q=0 on the compare edge with cyc_cnt=5.
  - Required: err=1 from the next cycle, first_fail_cyc=5, mismatch_cnt=1.
  - Further mismatches increment mismatch_cnt; first_fail_cyc stays at 5.
- Saturation plus mid-operation reset with CNT_W=2: apply 6 sets.
  - Required: set_cnt=3 and holds.
  - Then assert rst for one edge: all counters read 0 and err=0.
- With SR_FF_MONITOR_QB_CHECK_EN defined: drive q=1, qb=1 with model_q=1.
  - Required: mismatch_cnt=1, err=1.
  - Without the macro the same stimulus gives mismatch_cnt=0.
